// File: rtl/axi_id_remap_pkg.sv
// Shared defaults and helpers for the AXI ID remap slot table.
package axi_id_remap_pkg;

   localparam int unsigned AXI_ID_IN_DEF  = 8;
   localparam int unsigned AXI_ID_OUT_DEF = 4;
   localparam int unsigned ID_SLOT_DEF    = 16;
   localparam int unsigned MAX_TXNS_DEF   = 8;

   // Counter must hold 0..max_txns inclusive.
   function automatic int unsigned cnt_width(input int unsigned max_txns);
      return $clog2(max_txns + 1);
   endfunction

endpackage

// File: rtl/axi_id_remap_slot_find.sv
// Combinational slot search: busy slot holding the request ID, and lowest-index free slot.
module axi_id_remap_slot_find
   import axi_id_remap_pkg::*;
#(
   parameter int unsigned AXI_ID_IN = AXI_ID_IN_DEF,
   parameter int unsigned CNT_W     = 4,
   parameter int unsigned ID_SLOT   = ID_SLOT_DEF,
   parameter int unsigned IDX_W     = 4
) (
   input  logic [ID_SLOT-1:0][AXI_ID_IN-1:0] i_id_vec,
   input  logic [ID_SLOT-1:0][CNT_W-1:0]     i_cnt_vec,
   input  logic [AXI_ID_IN-1:0]              i_push_id,
   output logic                              o_match_valid,
   output logic [IDX_W-1:0]                  o_match_idx,
   output logic                              o_free_valid,
   output logic [IDX_W-1:0]                  o_free_idx
);

   logic             w_match_valid;
   logic [IDX_W-1:0] w_match_idx;
   logic             w_free_valid;
   logic [IDX_W-1:0] w_free_idx;

   always_comb begin
      w_match_valid = 1'b0;
      w_match_idx   = '0;
      w_free_valid  = 1'b0;
      w_free_idx    = '0;
      for (int i = 0; i < int'(ID_SLOT); i++) begin
         if (i_cnt_vec[i] != '0 && i_id_vec[i] == i_push_id && !w_match_valid) begin
            w_match_valid = 1'b1;
            w_match_idx   = IDX_W'(i);
         end
         if (i_cnt_vec[i] == '0 && !w_free_valid) begin
            w_free_valid = 1'b1;
            w_free_idx   = IDX_W'(i);
         end
      end
   end

   assign o_match_valid = w_match_valid;
   assign o_match_idx   = w_match_idx;
   assign o_free_valid  = w_free_valid;
   assign o_free_idx    = w_free_idx;

endmodule

// File: rtl/axi_id_remap_table.sv
// ID compression/restoration slot table for one AXI direction.
// Optional sticky illegal-pop flag err_o when AXI_ID_REMAP_TABLE_ERR_EN is defined.
module axi_id_remap_table
   import axi_id_remap_pkg::*;
#(
   parameter int unsigned AXI_ID_IN  = AXI_ID_IN_DEF,
   parameter int unsigned AXI_ID_OUT = AXI_ID_OUT_DEF,
   parameter int unsigned ID_SLOT    = ID_SLOT_DEF,
   parameter int unsigned MAX_TXNS   = MAX_TXNS_DEF
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  push_valid_i,
   output logic                  push_ready_o,
   input  logic [AXI_ID_IN-1:0]  push_id_i,
   output logic [AXI_ID_OUT-1:0] push_slot_o,
   input  logic                  pop_valid_i,
   input  logic                  pop_last_i,
   input  logic [AXI_ID_OUT-1:0] pop_slot_i,
   output logic [AXI_ID_IN-1:0]  pop_id_o,
   output logic                  empty_o,
   output logic                  full_o
`ifdef AXI_ID_REMAP_TABLE_ERR_EN
   ,
   output logic                  err_o
`endif
);

   localparam int unsigned CNT_W = cnt_width(MAX_TXNS);
   localparam int unsigned IDX_W = (ID_SLOT > 1) ? $clog2(ID_SLOT) : 1;
   localparam logic [CNT_W-1:0]    MAX_CNT  = CNT_W'(MAX_TXNS);
   localparam logic [AXI_ID_OUT:0] SLOT_LIM = (AXI_ID_OUT + 1)'(ID_SLOT);

   if (ID_SLOT > (2 ** AXI_ID_OUT)) begin : g_bad_cfg
      $error("ID_SLOT exceeds the narrow ID space 2**AXI_ID_OUT");
   end

   typedef struct packed {
      logic [AXI_ID_IN-1:0] id;
      logic [CNT_W-1:0]     cnt;
   } slot_t;

   slot_t [ID_SLOT-1:0] r_slot;

   logic [ID_SLOT-1:0][AXI_ID_IN-1:0] w_id_vec;
   logic [ID_SLOT-1:0][CNT_W-1:0]     w_cnt_vec;
   logic                              w_match_valid;
   logic [IDX_W-1:0]                  w_match_idx;
   logic                              w_free_valid;
   logic [IDX_W-1:0]                  w_free_idx;
   logic [IDX_W-1:0]                  w_sel_idx;
   logic                              w_push_fire;
   logic [IDX_W-1:0]                  w_pop_idx;
   logic                              w_pop_in_range;
   logic                              w_pop_slot_idle;
   logic                              w_pop_fire;
   logic [ID_SLOT-1:0]                w_inc;
   logic [ID_SLOT-1:0]                w_dec;
   logic                              w_empty;

   always_comb begin
      for (int i = 0; i < int'(ID_SLOT); i++) begin
         w_id_vec[i]  = r_slot[i].id;
         w_cnt_vec[i] = r_slot[i].cnt;
      end
   end

   axi_id_remap_slot_find #(
      .AXI_ID_IN (AXI_ID_IN),
      .CNT_W     (CNT_W),
      .ID_SLOT   (ID_SLOT),
      .IDX_W     (IDX_W)
   ) u_slot_find (
      .i_id_vec      (w_id_vec),
      .i_cnt_vec     (w_cnt_vec),
      .i_push_id     (push_id_i),
      .o_match_valid (w_match_valid),
      .o_match_idx   (w_match_idx),
      .o_free_valid  (w_free_valid),
      .o_free_idx    (w_free_idx)
   );

   // A saturated matching slot blocks the push; never fall back to a fresh slot.
   assign w_sel_idx    = w_match_valid ? w_match_idx : w_free_idx;
   assign push_ready_o = w_match_valid ? (r_slot[w_match_idx].cnt < MAX_CNT) : w_free_valid;
   assign w_push_fire  = push_valid_i & push_ready_o;

   always_comb begin
      push_slot_o              = '0;
      push_slot_o[IDX_W-1:0]   = w_sel_idx;
   end

   assign w_pop_idx       = pop_slot_i[IDX_W-1:0];
   assign w_pop_in_range  = {1'b0, pop_slot_i} < SLOT_LIM;
   assign w_pop_slot_idle = !w_pop_in_range || (r_slot[w_pop_idx].cnt == '0);
   assign w_pop_fire      = pop_valid_i & pop_last_i & !w_pop_slot_idle;
   assign pop_id_o        = w_pop_in_range ? r_slot[w_pop_idx].id : '0;

   always_comb begin
      w_empty = 1'b1;
      for (int i = 0; i < int'(ID_SLOT); i++) begin
         w_inc[i] = w_push_fire && (w_sel_idx == IDX_W'(i));
         w_dec[i] = w_pop_fire && (w_pop_idx == IDX_W'(i));
         if (r_slot[i].cnt != '0) w_empty = 1'b0;
      end
   end

   assign empty_o = w_empty;
   assign full_o  = !w_free_valid;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_slot <= '0;
      end else begin
         for (int i = 0; i < int'(ID_SLOT); i++) begin
            if (w_inc[i] && !w_dec[i]) begin
               r_slot[i].cnt <= r_slot[i].cnt + CNT_W'(1);
            end else if (w_dec[i] && !w_inc[i]) begin
               r_slot[i].cnt <= r_slot[i].cnt - CNT_W'(1);
            end
            if (w_inc[i] && !w_match_valid) r_slot[i].id <= push_id_i;
         end
      end
   end

`ifdef AXI_ID_REMAP_TABLE_ERR_EN
   logic r_err;

   // Any response beat without an outstanding transaction behind it is illegal.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_err <= 1'b0;
      end else if (pop_valid_i && w_pop_slot_idle) begin
         r_err <= 1'b1;
      end
   end

   assign err_o = r_err;
`endif

endmodule

// File: tb/tb_axi_id_remap_table.sv
// Self-checking bench for axi_id_remap_table: directed scenarios plus randomized traffic vs a model.
module tb_axi_id_remap_table;

   localparam int NSLOT = 16;
   localparam int MAXT  = 8;

   logic       clk_i = 1'b0;
   logic       rst_ni;
   logic       push_valid_i;
   logic       push_ready_o;
   logic [7:0] push_id_i;
   logic [3:0] push_slot_o;
   logic       pop_valid_i;
   logic       pop_last_i;
   logic [3:0] pop_slot_i;
   logic [7:0] pop_id_o;
   logic       empty_o;
   logic       full_o;
`ifdef AXI_ID_REMAP_TABLE_ERR_EN
   logic       err_o;
`endif

   always #5 clk_i = ~clk_i;

   axi_id_remap_table #(
      .AXI_ID_IN  (8),
      .AXI_ID_OUT (4),
      .ID_SLOT    (NSLOT),
      .MAX_TXNS   (MAXT)
   ) u_dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .push_valid_i (push_valid_i),
      .push_ready_o (push_ready_o),
      .push_id_i    (push_id_i),
      .push_slot_o  (push_slot_o),
      .pop_valid_i  (pop_valid_i),
      .pop_last_i   (pop_last_i),
      .pop_slot_i   (pop_slot_i),
      .pop_id_o     (pop_id_o),
      .empty_o      (empty_o),
      .full_o       (full_o)
`ifdef AXI_ID_REMAP_TABLE_ERR_EN
      ,
      .err_o        (err_o)
`endif
   );

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: per-slot original ID and outstanding count.
   logic [7:0] m_id [NSLOT];
   int         m_cnt[NSLOT];
   logic       m_err;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic void model_sel(input logic [7:0] pid, output logic rdy, output int slot);
      rdy  = 1'b0;
      slot = 0;
      for (int i = 0; i < NSLOT; i++) begin
         if (m_cnt[i] > 0 && m_id[i] == pid) begin
            slot = i;
            rdy  = (m_cnt[i] < MAXT);
            return;
         end
      end
      for (int i = 0; i < NSLOT; i++) begin
         if (m_cnt[i] == 0) begin
            slot = i;
            rdy  = 1'b1;
            return;
         end
      end
   endfunction

   function automatic logic model_empty();
      for (int i = 0; i < NSLOT; i++) if (m_cnt[i] > 0) return 1'b0;
      return 1'b1;
   endfunction

   function automatic logic model_full();
      for (int i = 0; i < NSLOT; i++) if (m_cnt[i] == 0) return 1'b0;
      return 1'b1;
   endfunction

   // Called at a negedge; drives one cycle, checks outputs, advances the model, ends at next negedge.
   task automatic step(input logic pv, input logic [7:0] pid, input logic qv, input logic ql,
                       input logic [3:0] qs, output logic obs_rdy, output logic [3:0] obs_slot);
      logic e_rdy;
      int   e_slot;
      logic pop_hit;
      push_valid_i = pv;
      push_id_i    = pid;
      pop_valid_i  = qv;
      pop_last_i   = ql;
      pop_slot_i   = qs;
      #1;
      model_sel(pid, e_rdy, e_slot);
      obs_rdy  = push_ready_o;
      obs_slot = push_slot_o;
      chk("push_ready", {31'd0, push_ready_o}, {31'd0, e_rdy});
      if (e_rdy) chk("push_slot", {28'd0, push_slot_o}, e_slot);
      chk("pop_id", {24'd0, pop_id_o}, {24'd0, m_id[qs]});
      chk("empty", {31'd0, empty_o}, {31'd0, model_empty()});
      chk("full", {31'd0, full_o}, {31'd0, model_full()});
`ifdef AXI_ID_REMAP_TABLE_ERR_EN
      chk("err", {31'd0, err_o}, {31'd0, m_err});
`endif
      @(posedge clk_i);
      pop_hit = qv && ql && (m_cnt[qs] > 0);
      if (qv && m_cnt[qs] == 0) m_err = 1'b1;
      if (pv && e_rdy) begin
         if (m_cnt[e_slot] == 0) m_id[e_slot] = pid;
         m_cnt[e_slot]++;
      end
      if (pop_hit) m_cnt[qs]--;
      @(negedge clk_i);
   endtask

   task automatic do_reset();
      rst_ni       = 1'b0;
      push_valid_i = 1'b0;
      push_id_i    = '0;
      pop_valid_i  = 1'b0;
      pop_last_i   = 1'b0;
      pop_slot_i   = '0;
      for (int i = 0; i < NSLOT; i++) begin
         m_id[i]  = '0;
         m_cnt[i] = 0;
      end
      m_err = 1'b0;
      #1;
      chk("rst_push_ready", {31'd0, push_ready_o}, 32'd1);
      chk("rst_push_slot", {28'd0, push_slot_o}, 32'd0);
      chk("rst_pop_id", {24'd0, pop_id_o}, 32'd0);
      chk("rst_empty", {31'd0, empty_o}, 32'd1);
      chk("rst_full", {31'd0, full_o}, 32'd0);
`ifdef AXI_ID_REMAP_TABLE_ERR_EN
      chk("rst_err", {31'd0, err_o}, 32'd0);
`endif
      @(negedge clk_i);
      rst_ni = 1'b1;
   endtask

   initial begin
      logic       r;
      logic [3:0] s;
      logic [7:0] rid;

      do_reset();

      // Compression, reuse of a matching slot, restoration and slot recycling.
      step(1'b1, 8'hA5, 1'b0, 1'b0, 4'd0, r, s);
      chk("a5_slot", {28'd0, s}, 32'd0);
      chk("a5_not_empty", {31'd0, empty_o}, 32'd0);
      step(1'b1, 8'hA5, 1'b0, 1'b0, 4'd0, r, s);
      chk("a5_again_slot", {28'd0, s}, 32'd0);
      step(1'b1, 8'h3C, 1'b0, 1'b0, 4'd0, r, s);
      chk("3c_slot", {28'd0, s}, 32'd1);
      step(1'b0, 8'h00, 1'b1, 1'b1, 4'd0, r, s);
      chk("pop0_id_a", {24'd0, pop_id_o}, 32'h0A5);
      step(1'b0, 8'h00, 1'b1, 1'b1, 4'd0, r, s);
      step(1'b1, 8'h11, 1'b0, 1'b0, 4'd0, r, s);
      chk("11_slot", {28'd0, s}, 32'd0);

      // Saturation of one slot does not block a different ID.
      do_reset();
      for (int i = 0; i < MAXT; i++) step(1'b1, 8'h07, 1'b0, 1'b0, 4'd0, r, s);
      step(1'b1, 8'h07, 1'b0, 1'b0, 4'd0, r, s);
      chk("07_saturated", {31'd0, r}, 32'd0);
      step(1'b1, 8'h08, 1'b0, 1'b0, 4'd0, r, s);
      chk("08_ready", {31'd0, r}, 32'd1);
      chk("08_slot", {28'd0, s}, 32'd1);

      // Full table; a slot freed this cycle is only reusable next cycle.
      do_reset();
      for (int i = 0; i < NSLOT; i++) step(1'b1, 8'(8'h80 + i), 1'b0, 1'b0, 4'd0, r, s);
      chk("full_set", {31'd0, full_o}, 32'd1);
      step(1'b1, 8'hF0, 1'b0, 1'b0, 4'd0, r, s);
      chk("full_blocks", {31'd0, r}, 32'd0);
      step(1'b1, 8'hF0, 1'b1, 1'b1, 4'd5, r, s);
      chk("freed_same_cycle", {31'd0, r}, 32'd0);
      step(1'b1, 8'hF0, 1'b0, 1'b0, 4'd0, r, s);
      chk("freed_next_rdy", {31'd0, r}, 32'd1);
      chk("freed_next_slot", {28'd0, s}, 32'd5);

      // Simultaneous push/pop on one slot, and non-last beats.
      do_reset();
      step(1'b1, 8'h40, 1'b0, 1'b0, 4'd0, r, s);
      step(1'b1, 8'h41, 1'b0, 1'b0, 4'd0, r, s);
      step(1'b1, 8'h42, 1'b0, 1'b0, 4'd0, r, s);
      step(1'b1, 8'h42, 1'b1, 1'b1, 4'd2, r, s);
      chk("pushpop_slot", {28'd0, s}, 32'd2);
      step(1'b0, 8'h00, 1'b1, 1'b0, 4'd2, r, s);
      chk("nonlast_id", {24'd0, pop_id_o}, 32'h042);
      step(1'b0, 8'h00, 1'b1, 1'b1, 4'd2, r, s);
      step(1'b1, 8'h99, 1'b0, 1'b0, 4'd0, r, s);
      chk("cnt_was_one", {28'd0, s}, 32'd2);

`ifdef AXI_ID_REMAP_TABLE_ERR_EN
      do_reset();
      step(1'b1, 8'h21, 1'b0, 1'b0, 4'd0, r, s);
      step(1'b0, 8'h00, 1'b1, 1'b1, 4'd9, r, s);
      chk("err_set", {31'd0, err_o}, 32'd1);
      chk("err_state_kept", {31'd0, empty_o}, 32'd0);
      for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h30 + i), 1'b0, 1'b0, 4'd0, r, s);
      chk("err_sticky", {31'd0, err_o}, 32'd1);
`endif

      // Randomized traffic with a small ID pool so matches, saturation and fullness occur.
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         rid = ($urandom_range(0, 3) == 0) ? 8'h07 : 8'($urandom_range(0, 19));
         step(($urandom_range(0, 9) < 6), rid, ($urandom_range(0, 9) < 6),
              ($urandom_range(0, 9) < 7), 4'($urandom_range(0, NSLOT - 1)), r, s);
      end

      // Reset with traffic outstanding returns every output to its reset value.
      do_reset();
      step(1'b1, 8'h5A, 1'b0, 1'b0, 4'd0, r, s);
      chk("post_rst_slot", {28'd0, s}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
